// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state type, defaults and clear data for run_ctrl (S_FAULT only with RUN_CTRL_TIMEOUT_EN)
package run_ctrl_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int TIMEOUT_DEF = 4095;
    localparam logic [7:0] CLR_DAT = 8'h00;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_BOOT,
        S_RUN,
        S_DONE
`ifdef RUN_CTRL_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;
endpackage

// File: rtl/run_ctrl.sv
// run_ctrl: clears data memory, boots the core and times its run; RUN_CTRL_TIMEOUT_EN adds a cycle-limit FAULT state
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter logic [7:0] CLR_LO = 8'd0,
    parameter logic [7:0] CLR_HI = 8'd255,
    parameter int CNT_W = CNT_W_DEF
`ifdef RUN_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    output logic             ack,
    output logic             busy,
    output logic             core_reset,
    input  logic             core_done,
    output logic             clr_wr_en,
    output logic [7:0]       clr_addr,
    output logic [7:0]       clr_dat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             timeout
);
    state_t state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic ack_q, busy_q, core_reset_q, wr_en_q;

    // next state, clear address and cycle counter; a dropped req always wins
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: if (req) begin
                state_d = S_CLEAR;
                addr_d = CLR_LO;
                cnt_d = '0;
            end
            S_CLEAR: begin
                if (!req) state_d = S_IDLE;
                else if (addr_q == CLR_HI) state_d = S_BOOT;
                else addr_d = addr_q + 8'd1;
            end
            S_BOOT: state_d = req ? S_RUN : S_IDLE;
            S_RUN: begin
                cnt_d = cnt_inc;
                if (!req) state_d = S_IDLE;
                else if (core_done) state_d = S_DONE;
`ifdef RUN_CTRL_TIMEOUT_EN
                else if (cnt_inc == CNT_W'(TIMEOUT)) state_d = S_FAULT;
`endif
            end
            S_DONE: if (!req) state_d = S_IDLE;
`ifdef RUN_CTRL_TIMEOUT_EN
            S_FAULT: if (!req) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // state, counters and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q <= CLR_LO;
            cnt_q <= '0;
            ack_q <= 1'b0;
            busy_q <= 1'b0;
            core_reset_q <= 1'b1;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
`ifdef RUN_CTRL_TIMEOUT_EN
            ack_q <= (state_d == S_DONE) || (state_d == S_FAULT);
`else
            ack_q <= state_d == S_DONE;
`endif
            busy_q <= (state_d == S_CLEAR) || (state_d == S_BOOT) || (state_d == S_RUN);
            core_reset_q <= state_d != S_RUN;
            wr_en_q <= state_d == S_CLEAR;
        end
    end

`ifdef RUN_CTRL_TIMEOUT_EN
    logic timeout_q;

    // timeout flag mirrors residence in FAULT
    always_ff @(posedge clk) begin
        if (reset) timeout_q <= 1'b0;
        else timeout_q <= state_d == S_FAULT;
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign ack = ack_q;
    assign busy = busy_q;
    assign core_reset = core_reset_q;
    assign clr_wr_en = wr_en_q;
    assign clr_addr = addr_q;
    assign clr_dat = CLR_DAT;
    assign cycle_cnt = cnt_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl with CLR_LO=0, CLR_HI=3, TIMEOUT=20 (RUN_CTRL_TIMEOUT_EN selects the limit tests)
module tb_run_ctrl;
    logic clk = 1'b0;
    logic reset, req, core_done;
    logic ack, busy, core_reset, clr_wr_en, timeout;
    logic [7:0] clr_addr, clr_dat;
    logic [15:0] cycle_cnt;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .CLR_LO(8'd0),
        .CLR_HI(8'd3),
        .CNT_W(16)
`ifdef RUN_CTRL_TIMEOUT_EN
        , .TIMEOUT(20)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .ack(ack),
        .busy(busy),
        .core_reset(core_reset),
        .core_done(core_done),
        .clr_wr_en(clr_wr_en),
        .clr_addr(clr_addr),
        .clr_dat(clr_dat),
        .cycle_cnt(cycle_cnt),
        .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_run();
        req = 1'b1;
        repeat (6) tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_crst"}, 32'(core_reset), 1);
        chk({tag, "_wr"}, 32'(clr_wr_en), 0);
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0;
        core_done = 1'b0;
        repeat (2) tick();
        chk_idle("rst");
        chk("rst_addr", 32'(clr_addr), 0);
        chk("rst_cnt", 32'(cycle_cnt), 0);
        chk("rst_to", 32'(timeout), 0);
        reset = 1'b0;
        core_done = 1'b1;
        tick();
        chk("idle_done_ign", 32'(busy), 0);
        core_done = 1'b0;
        req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("clr_wr%0d", i), 32'(clr_wr_en), 1);
            chk($sformatf("clr_addr%0d", i), 32'(clr_addr), 32'(i));
            chk($sformatf("clr_dat%0d", i), 32'(clr_dat), 0);
            chk($sformatf("clr_busy%0d", i), 32'(busy), 1);
            tick();
        end
        chk("boot_wr", 32'(clr_wr_en), 0);
        chk("boot_crst", 32'(core_reset), 1);
        chk("boot_busy", 32'(busy), 1);
        chk("boot_addr", 32'(clr_addr), 3);
        tick();
        chk("run_crst", 32'(core_reset), 0);
        chk("run_cnt0", 32'(cycle_cnt), 0);
        for (int k = 1; k <= 6; k++) begin
            core_done = (k == 6);
            tick();
        end
        core_done = 1'b0;
        chk("done_ack", 32'(ack), 1);
        chk("done_cnt", 32'(cycle_cnt), 6);
        chk("done_crst", 32'(core_reset), 1);
        chk("done_busy", 32'(busy), 0);
        core_done = 1'b1;
        repeat (3) tick();
        core_done = 1'b0;
        chk("done_hold_ack", 32'(ack), 1);
        chk("done_hold_cnt", 32'(cycle_cnt), 6);
        req = 1'b0;
        tick();
        chk_idle("done_exit");
        chk("idle_cnt_kept", 32'(cycle_cnt), 6);
        tick();
        chk("idle_stay", 32'(busy), 0);

        req = 1'b1;
        repeat (2) tick();
        chk("abort_pre_addr", 32'(clr_addr), 1);
        req = 1'b0;
        tick();
        chk_idle("abort");
        repeat (3) tick();
        chk("abort_ack_late", 32'(ack), 0);

        go_run();
        repeat (3) tick();
        chk("mid_cnt3", 32'(cycle_cnt), 3);
        reset = 1'b1;
        tick();
        chk_idle("mrst");
        chk("mrst_cnt", 32'(cycle_cnt), 0);
        chk("mrst_addr", 32'(clr_addr), 0);
        reset = 1'b0;
        req = 1'b0;
        tick();

        go_run();
        repeat (2) tick();
        core_done = 1'b1;
        req = 1'b0;
        tick();
        core_done = 1'b0;
        chk_idle("simul");
        tick();
        chk("simul_ack_late", 32'(ack), 0);

`ifdef RUN_CTRL_TIMEOUT_EN
        go_run();
        repeat (19) tick();
        chk("to_pre", 32'(timeout), 0);
        chk("to_pre_busy", 32'(busy), 1);
        tick();
        chk("to_flag", 32'(timeout), 1);
        chk("to_ack", 32'(ack), 1);
        chk("to_crst", 32'(core_reset), 1);
        chk("to_cnt", 32'(cycle_cnt), 20);
        chk("to_busy", 32'(busy), 0);
        repeat (2) tick();
        chk("to_hold", 32'(timeout), 1);
        req = 1'b0;
        tick();
        chk("to_clear", 32'(timeout), 0);
        chk_idle("to_exit");
        go_run();
        repeat (19) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("tw_ack", 32'(ack), 1);
        chk("tw_to", 32'(timeout), 0);
        chk("tw_cnt", 32'(cycle_cnt), 20);
        req = 1'b0;
        tick();
        chk_idle("tw_exit");
`else
        go_run();
        repeat (99) tick();
        chk("long_to99", 32'(timeout), 0);
        chk("long_busy99", 32'(busy), 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("long_ack", 32'(ack), 1);
        chk("long_cnt", 32'(cycle_cnt), 100);
        chk("long_to", 32'(timeout), 0);
        req = 1'b0;
        tick();
        chk_idle("long_exit");
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
- REQ-001: Parameters SHALL be:
  - CLR_LO, 8'd0, first data-memory address cleared before a run.
  - CLR_HI, 8'd255, last address cleared (inclusive); CLR_LO <= CLR_HI required.
  - CNT_W, 16, cycle counter width.
  - TIMEOUT, 4095, RUN-cycle limit, used only with RUN_CTRL_TIMEOUT_EN.
- REQ-002: Ports SHALL be:
  - clk, in, 1, single clock; one clock.
  - reset, in, 1, reset is synchronous and active-high.
  - req, in, 1, run request level from the host.
  - ack, out, 1, run finished (done or fault), held until req falls.
  - busy, out, 1, run sequence in progress.
  - core_reset, out, 1, drives the processor core reset.
  - core_done, in, 1, processor done flag.
  - clr_wr_en, out, 1, data-memory write enable during the clear phase.
  - clr_addr, out, 8, data-memory address during the clear phase.
  - clr_dat, out, 8, clear data, constant 8'h00.
  - cycle_cnt, out, CNT_W, RUN cycles of the last or current run.
  - timeout, out, 1, run aborted by the cycle limit.

Function
- REQ-003: The FSM SHALL have states IDLE, CLEAR, BOOT, RUN, DONE and FAULT; FAULT exists only with the macro; all outputs SHALL be registered.
- REQ-004: In IDLE, core_reset SHALL be 1. req=1 sampled SHALL go to CLEAR, clear cycle_cnt to 0, and load clr_addr with CLR_LO.
- REQ-005: In CLEAR, each cycle SHALL assert clr_wr_en=1 and write one word.
  - clr_addr SHALL increment by 1 per cycle.
  - The phase SHALL take exactly CLR_HI-CLR_LO+1 cycles.
  - After the write to CLR_HI the FSM SHALL go to BOOT; clr_addr SHALL NOT wrap.
- REQ-006: BOOT SHALL last exactly 1 cycle with core_reset=1 (program counter returns to 0), then go to RUN.
- REQ-007: In RUN, core_reset SHALL be 0.
  - cycle_cnt SHALL increment by 1 each cycle, including the cycle in which core_done is sampled.
  - cycle_cnt SHALL saturate at all-ones.
- REQ-008: core_done=1 sampled in RUN SHALL go to DONE. core_done SHALL be ignored in every other state.
- REQ-009: In DONE, ack=1, core_reset=1 and cycle_cnt SHALL hold. req=0 sampled SHALL return the FSM to IDLE, with ack=0 from the next cycle.
- REQ-010: busy SHALL be 1 exactly in CLEAR, BOOT and RUN.
- REQ-011: req=0 sampled in CLEAR, BOOT or RUN SHALL abort to IDLE.
  - ack SHALL NOT assert on an abort.
  - clr_wr_en SHALL drop in the next cycle.
  - An abort SHALL win over a simultaneous core_done.
- REQ-012: req held high through DONE or FAULT SHALL NOT start a new run; a new run needs a 0-to-1 sequence through IDLE.

Reset
- REQ-013: Synchronous reset SHALL force:
  - state=IDLE;
  - core_reset=1;
  - ack, busy, clr_wr_en and timeout to 0;
  - clr_addr=CLR_LO;
  - cycle_cnt=0.
- REQ-014: Reset asserted in any state, including mid-CLEAR or mid-RUN, SHALL take priority over all other transitions.

Configuration
- REQ-015: With RUN_CTRL_TIMEOUT_EN defined, RUN SHALL go to FAULT on the cycle when cycle_cnt reaches TIMEOUT without core_done.
  - core_done in that same cycle SHALL win, going to DONE.
  - FAULT SHALL drive ack=1, timeout=1 and core_reset=1, and exit to IDLE on req=0.
  - timeout SHALL clear on leaving FAULT.
- REQ-016: Without RUN_CTRL_TIMEOUT_EN, the FAULT state and TIMEOUT SHALL be absent, timeout SHALL be tied to 0, and RUN SHALL wait indefinitely.

Structure
- REQ-017: Shared package run_ctrl_pkg SHALL hold:
  - the state enum typedef;
  - the default CNT_W and TIMEOUT constants;
  - the clear-data constant 8'h00.
- REQ-018: The block SHALL be a single module with no sub-module; the clear-address counter and cycle counter SHALL be inline.
- REQ-019: Integration wiring SHALL be as follows:
  - core_reset drives the processor reset;
  - clr_* is muxed onto the data-memory write port while busy and not in RUN;
  - core_done is fed from the processor done flag.

Verification (bench parameters CLR_LO=0, CLR_HI=3, TIMEOUT=20)
- REQ-020: Nominal run: raise req with core_done pulsed in the 6th RUN cycle. Required response:
  - writes to addresses 0,1,2,3 with data 0;
  - one BOOT cycle;
  - cycle_cnt=6;
  - ack=1 the next cycle;
  - req=0 gives ack=0 and IDLE.
- REQ-021: Abort: drop req in the 2nd CLEAR cycle. Required response: IDLE, clr_wr_en=0 from the next cycle, core_reset=1, ack never 1.
- REQ-022: Reset mid-RUN after 3 cycles. Required response: all outputs at reset values next cycle, cycle_cnt=0.
- REQ-023: Simultaneous events: core_done=1 and req=0 in the same RUN cycle. Required response: IDLE, ack stays 0.
- REQ-024: With the macro, core_done never asserted. Required response: FAULT when cycle_cnt=20, timeout=1, ack=1, core_reset=1. Repeating with core_done at cycle 20 SHALL give DONE with timeout=0.
- REQ-025: Without the macro, core_done asserted after 100 cycles. Required response: timeout stays 0, DONE reached, cycle_cnt=100.
